axi_counter_bank: RTL and testbench
===================================

Name: axi_counter_bank

Overview:
- Bank of NUM_CH free-running up-counters, each CNT_WIDTH bits, in a single clock domain, with an AXI4-Lite slave (64-bit data) for read, load and control.
- Generalises the single 64-bit readable counter: multi-channel, configurable width, per-channel enable, software load with byte strobes, decode error responses.
- Sits on the peripheral AXI-Lite interconnect as a timestamp/event-count resource.

Parameters:
- NUM_CH, 4, number of counter channels (1..16)
- CNT_WIDTH, 64, counter width in bits (1..64)
- RST_ENABLE, 1, reset value of every channel's enable bit (0 or 1)

Ports:
- aclk  in  1  single clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  12  write byte address
- awprot  in  3  ignored
- wvalid/wready  in/out  1  write data handshake
- wdata  in  64  write data
- wstrb  in  8  byte strobes
- bvalid/bready  out/in  1  write response handshake
- bresp  out  2  OKAY=2'b00, SLVERR=2'b10
- arvalid/arready  in/out  1  read address handshake
- araddr  in  12  read byte address
- arprot  in  3  ignored
- rvalid/rready  out/in  1  read data handshake
- rdata  out  64  read data
- rresp  out  2  as bresp
- irq  out  1  level interrupt (see Optional Feature)

Behaviour:
- Reset (aresetn low, async): all counters 0, enables = RST_ENABLE, bvalid=0, rvalid=0, rdata=0, bresp=rresp=0, irq=0. arready/awready/wready are combinational and read 1 during reset. Reset mid-transaction drops it; no response is issued.
- Address map: ch = addr[7:4]; addr[3]=0 -> COUNT, addr[3]=1 -> CTRL; addr[2:0] ignored. ch >= NUM_CH or addr[11:8] != 0 -> decode error.
- COUNT: reads counter zero-extended to 64 bits. A write loads each byte lane with wstrb set; bits >= CNT_WIDTH are discarded.
- CTRL: bit0 = enable (RW); other bits read 0 unless the Optional Feature is enabled.
- Counting: an enabled channel increments by 1 every aclk edge and wraps from 2^CNT_WIDTH-1 to 0.
- Same-cycle load and increment on one channel: the load wins; the loaded value appears next cycle and increments the cycle after that.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready=1. On arvalid, latch a snapshot of the addressed register at that edge into rdata, set rresp, set rvalid=1, go to R_RESP.
  - R_RESP: arready=0. rdata is held until rvalid&&rready, then rvalid=0 and return to R_IDLE.
  - Read latency is 1 cycle after the AR handshake. Decode error: rdata=0, rresp=SLVERR.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready=wready=1 only when awvalid&&wvalid are both high. Address and data are accepted in the same cycle. The register update takes effect at that edge; then bvalid=1, go to W_RESP.
  - W_RESP: awready=wready=0. Return to W_IDLE on bvalid&&bready.
  - Decode error: no state change, bresp=SLVERR.
- Read and write channels are independent. A read accepted in the same cycle as a write to the same register returns the pre-write value.
- Max one outstanding read and one outstanding write.

Optional Feature:
- Macro: AXI_COUNTER_BANK_OVF_IRQ_EN.
- Defined:
  - CTRL bit1 = sticky overflow flag, set when a channel wraps to 0 by increment (not by load). Write-1-to-clear with wstrb[0].
  - CTRL bit2 = overflow interrupt enable (RW, reset 0).
  - irq registered: irq = OR over channels of (bit1 & bit2), updated one cycle after the flag changes.
  - If a wrap and a W1C clear hit the same cycle, the set wins.
- Undefined: bits 1 and 2 read 0, writes to them are ignored, irq is tied 0, no flag storage is built.

Test Plan:
- Reset then wait 10 cycles, NUM_CH=4, RST_ENABLE=1: read ch2 COUNT -> value in 10..12, rresp=OKAY, rvalid exactly 1 cycle after the AR handshake.
- Write ch1 COUNT wdata=64'h0000_0000_1234_5678 with wstrb=8'h0F and the channel disabled; read back -> 64'h12345678. Write wstrb=8'h01 with wdata=0xAB -> 64'h123456AB.
- CNT_WIDTH=8, ch0 enabled: load 0xFE, then read on consecutive reads -> values advance and wrap to 0x00..; upper 56 bits read 0. With macro: CTRL bit1=1 after the wrap; set bit2 -> irq=1; write CTRL 0x7 -> bit1 cleared, irq=0 next cycle.
- Read 0x040 (ch4 with NUM_CH=4) and 0x100 -> rdata=0, rresp=SLVERR. Write to the same addresses -> bresp=SLVERR, all counters unaffected.
- Hold rready=0 for 5 cycles after a read: rdata stable, arready=0 throughout, a second arvalid is not accepted until the R handshake completes. Same check for bready on the write path.
- Assert aresetn=0 while in R_RESP and W_RESP: rvalid=bvalid=0 immediately, counters 0, enables = RST_ENABLE.

Source files
------------

// File: rtl/axi_counter_bank.sv
// NUM_CH free-running counters behind an AXI4-Lite slave: read data 1 cycle after AR, one outstanding read and one write.
// Optional AXI_COUNTER_BANK_OVF_IRQ_EN adds per-channel sticky overflow flags, interrupt enables and a registered irq.
module axi_counter_bank #(
   parameter int NUM_CH     = 4,
   parameter int CNT_WIDTH  = 64,
   parameter bit RST_ENABLE = 1'b1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        awvalid,
   output logic        awready,
   input  logic [11:0] awaddr,
   input  logic [2:0]  awprot,
   input  logic        wvalid,
   output logic        wready,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   input  logic        arvalid,
   output logic        arready,
   input  logic [11:0] araddr,
   input  logic [2:0]  arprot,
   output logic        rvalid,
   input  logic        rready,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   output logic        irq
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_RESP} r_state_t;
   typedef enum logic {W_IDLE, W_RESP} w_state_t;

   r_state_t r_state, r_state_nxt;
   w_state_t w_state, w_state_nxt;

   logic [CNT_WIDTH-1:0] cnt [NUM_CH];
   logic [NUM_CH-1:0]    en;
   logic [NUM_CH-1:0]    ld_sel;
   logic [NUM_CH-1:0]    ctrl_sel;
   logic                 ar_fire;
   logic                 aw_fire;
   logic                 rd_ok;
   logic                 wr_ok;
   logic [63:0]          rd_val;

   // Protection bits and the sub-word address bits carry no meaning here.
   logic unused;
   assign unused = ^{awprot, arprot, awaddr[2:0], araddr[2:0], wdata, wstrb};

   function automatic logic addr_ok(input logic [11:0] a);
      return (a[11:8] == 4'd0) && (int'({28'd0, a[7:4]}) < NUM_CH);
   endfunction

   // Byte lanes without a strobe keep the current count; bits above CNT_WIDTH fall away.
   function automatic logic [CNT_WIDTH-1:0] merge_bytes(input logic [CNT_WIDTH-1:0] cur,
                                                        input logic [63:0] d,
                                                        input logic [7:0] s);
      logic [CNT_WIDTH-1:0] v;
      for (int i = 0; i < CNT_WIDTH; i++) v[i] = s[i/8] ? d[i] : cur[i];
      return v;
   endfunction

   assign ar_fire = (r_state == R_IDLE) && arvalid;
   assign aw_fire = (w_state == W_IDLE) && awvalid && wvalid;

   always_comb begin
      ld_sel   = '0;
      ctrl_sel = '0;
      wr_ok    = addr_ok(awaddr);
      for (int i = 0; i < NUM_CH; i++) begin
         if (aw_fire && wr_ok && int'({28'd0, awaddr[7:4]}) == i) begin
            ld_sel[i]   = !awaddr[3];
            ctrl_sel[i] = awaddr[3] && wstrb[0];
         end
      end
   end

   // A load on a channel suppresses that cycle's increment.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         en <= {NUM_CH{RST_ENABLE}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ld_sel[i])   cnt[i] <= merge_bytes(cnt[i], wdata, wstrb);
            else if (en[i])  cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            if (ctrl_sel[i]) en[i]  <= wdata[0];
         end
      end
   end

`ifdef AXI_COUNTER_BANK_OVF_IRQ_EN
   logic [NUM_CH-1:0] ovf;
   logic [NUM_CH-1:0] ien;

   // The wrap set is assigned last so it beats a same-cycle write-1-to-clear.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ovf <= '0;
         ien <= '0;
         irq <= 1'b0;
      end else begin
         irq <= |(ovf & ien);
         for (int i = 0; i < NUM_CH; i++) begin
            if (ctrl_sel[i]) begin
               ien[i] <= wdata[2];
               if (wdata[1]) ovf[i] <= 1'b0;
            end
            if (en[i] && !ld_sel[i] && (&cnt[i])) ovf[i] <= 1'b1;
         end
      end
   end
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_val = '0;
      rd_ok  = addr_ok(araddr);
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ok && int'({28'd0, araddr[7:4]}) == i) begin
            if (!araddr[3]) rd_val = 64'(cnt[i]);
`ifdef AXI_COUNTER_BANK_OVF_IRQ_EN
            else            rd_val = {61'd0, ien[i], ovf[i], en[i]};
`else
            else            rd_val = {63'd0, en[i]};
`endif
         end
      end
   end

   always_comb begin
      r_state_nxt = r_state;
      arready     = 1'b0;
      rvalid      = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) r_state_nxt = R_RESP;
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Ready is offered while held in reset so the slave never looks stalled to the fabric.
   always_comb begin
      w_state_nxt = w_state;
      awready     = 1'b0;
      wready      = 1'b0;
      bvalid      = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = (awvalid && wvalid) || !aresetn;
            wready  = (awvalid && wvalid) || !aresetn;
            if (awvalid && wvalid) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
         bresp   <= RESP_OKAY;
      end else begin
         r_state <= r_state_nxt;
         w_state <= w_state_nxt;
         if (ar_fire) begin
            rdata <= rd_val;
            rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
         if (aw_fire) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end
endmodule

// File: tb/tb_axi_counter_bank.sv
// Randomized AXI-Lite traffic against a counter bank model that tracks each channel as base value plus elapsed edges.
module tb_axi_counter_bank;
   localparam int NCH = 4;
   localparam int W = 16;
   localparam bit RSTEN = 1'b1;
   localparam longint unsigned MOD = 64'd1 << W;
`ifdef AXI_COUNTER_BANK_OVF_IRQ_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [11:0] awaddr = '0, araddr = '0;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0]  bresp, rresp;
   logic [63:0] rdata;

   axi_counter_bank #(.NUM_CH(NCH), .CNT_WIDTH(W), .RST_ENABLE(RSTEN)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(3'b000),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'b000),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .irq(irq)
   );

   always #5 aclk = ~aclk;

   // After clock edge n has happened, cyc == n.
   longint cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   longint unsigned base_m [NCH];
   longint          t0_m   [NCH];
   bit              en_m   [NCH];
   bit              ovf_m  [NCH];
   bit              ien_m  [NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic bit m_ok(input logic [11:0] a);
      return (a[11:8] == 4'd0) && (int'({28'd0, a[7:4]}) < NCH);
   endfunction

   function automatic longint unsigned mval(input int ch, input longint n);
      longint unsigned v;
      v = base_m[ch];
      if (en_m[ch]) v = v + 64'(n - t0_m[ch]);
      return v % MOD;
   endfunction

   // True when at least one increment wrap happened in edges (t0, n].
   function automatic bit mwrapped(input int ch, input longint n);
      return en_m[ch] && (base_m[ch] + 64'(n - t0_m[ch]) >= MOD);
   endfunction

   function automatic bit mflag(input int ch, input longint n);
      return OVF && (ovf_m[ch] || mwrapped(ch, n));
   endfunction

   function automatic bit exp_irq(input longint n);
      bit x;
      x = 1'b0;
      for (int ch = 0; ch < NCH; ch++) x = x | (mflag(ch, n - 1) && ien_m[ch]);
      return x;
   endfunction

   function automatic void model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         base_m[ch] = 0;
         t0_m[ch]   = cyc;
         en_m[ch]   = RSTEN;
         ovf_m[ch]  = 1'b0;
         ien_m[ch]  = 1'b0;
      end
   endfunction

   function automatic void exp_read(input logic [11:0] a, input longint n,
                                    output logic [63:0] d, output logic [1:0] r);
      int ch;
      d = '0;
      r = 2'b10;
      if (m_ok(a)) begin
         ch = int'(a[7:4]);
         r = 2'b00;
         if (!a[3]) d = mval(ch, n);
         else       d = {61'd0, (ien_m[ch] && OVF), mflag(ch, n), en_m[ch]};
      end
   endfunction

   // Register update taking effect at clock edge e.
   function automatic void model_write(input logic [11:0] a, input logic [63:0] d,
                                       input logic [7:0] s, input longint e);
      int ch;
      logic [63:0] v;
      bit wrap_e;
      if (!m_ok(a)) return;
      ch = int'(a[7:4]);
      if (!a[3]) begin
         ovf_m[ch] = mflag(ch, e - 1);
         v = mval(ch, e - 1);
         for (int b = 0; b < 8; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
         base_m[ch] = v % MOD;
         t0_m[ch]   = e;
      end else if (s[0]) begin
         wrap_e = en_m[ch] && (mval(ch, e - 1) == MOD - 1);
         v = mval(ch, e);
         ovf_m[ch]  = d[1] ? (OVF && wrap_e) : mflag(ch, e);
         ien_m[ch]  = OVF && d[2];
         en_m[ch]   = d[0];
         base_m[ch] = v;
         t0_m[ch]   = e;
      end
   endfunction

   task automatic do_read(input string tag, input logic [11:0] addr, input int hold,
                          input bit poke, output logic [63:0] d);
      logic [63:0] ed;
      logic [1:0]  er;
      longint      hs;
      int          n;
      araddr  = addr;
      arvalid = 1'b1;
      #1;
      n = 0;
      while (!arready && n < 50) begin
         @(posedge aclk);
         #2;
         n++;
      end
      chk({tag, "_arready"}, arready, 1);
      hs = cyc + 1;
      exp_read(addr, hs - 1, ed, er);
      tick();
      arvalid = 1'b0;
      chk({tag, "_rvalid"}, rvalid, 1);
      d = rdata;
      chk({tag, "_rdata"}, rdata, ed);
      chk({tag, "_rresp"}, rresp, er);
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            arvalid = 1'b1;
            araddr  = addr ^ 12'h008;
         end
         tick();
         chk({tag, "_hold_rdata"}, rdata, d);
         chk({tag, "_hold_rvalid"}, rvalid, 1);
         chk({tag, "_hold_arready"}, arready, 0);
      end
      rready = 1'b1;
      tick();
      rready  = 1'b0;
      arvalid = 1'b0;
      chk({tag, "_rvalid_done"}, rvalid, 0);
   endtask

   task automatic do_write(input string tag, input logic [11:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input int hold, input bit poke);
      longint he;
      int     n;
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      #1;
      n = 0;
      while (!awready && n < 50) begin
         @(posedge aclk);
         #2;
         n++;
      end
      chk({tag, "_awready"}, awready, 1);
      he = cyc + 1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      model_write(addr, data, strb, he);
      chk({tag, "_bvalid"}, bvalid, 1);
      chk({tag, "_bresp"}, bresp, m_ok(addr) ? 2'b00 : 2'b10);
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
         end
         tick();
         chk({tag, "_hold_bvalid"}, bvalid, 1);
         chk({tag, "_hold_awready"}, awready, 0);
         chk({tag, "_hold_wready"}, wready, 0);
      end
      bready = 1'b1;
      tick();
      bready  = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk({tag, "_bvalid_done"}, bvalid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [63:0] d;
      #2 aresetn = 1'b0;
      repeat (3) tick();
      chk("rst_rvalid", rvalid, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_resp", {bresp, rresp}, 0);
      chk("rst_irq", irq, 0);
      chk("rst_arready", arready, 1);
      chk("rst_awready", awready, 1);
      aresetn = 1'b1;
      model_reset();

      repeat (10) tick();
      do_read("t1_ch2", 12'h020, 0, 0, d);
      chk("t1_range", (d >= 10 && d <= 12), 1);

      do_write("t2_dis", 12'h018, 64'h0, 8'h01, 0, 0);
      do_write("t2_ld", 12'h010, 64'h0000_0000_1234_5678, 8'h0F, 0, 0);
      do_read("t2_rd", 12'h010, 0, 0, d);
      chk("t2_val", d, 64'h5678);
      do_write("t2_lane", 12'h010, 64'hAB, 8'h01, 0, 0);
      do_read("t2_rd2", 12'h014, 0, 0, d);
      chk("t2_val2", d, 64'h56AB);

      do_write("t3_ld", 12'h000, 64'hFFFF_FFFF_FFFF_FFFE, 8'h03, 0, 0);
      for (int i = 0; i < 3; i++) begin
         do_read("t3_rd", 12'h000, 0, 0, d);
         chk("t3_upper", d[63:W], 0);
      end
      chk("t3_wrapped", d < 16, 1);
`ifdef AXI_COUNTER_BANK_OVF_IRQ_EN
      do_read("ovf_flag", 12'h008, 0, 0, d);
      chk("ovf_bit1", d[1], 1);
      do_write("ovf_ien", 12'h008, 64'h5, 8'h01, 0, 0);
      chk("ovf_irq_on", irq, exp_irq(cyc));
      chk("ovf_irq_on_c", irq, 1);
      do_write("ovf_clr", 12'h008, 64'h7, 8'h01, 0, 0);
      chk("ovf_irq_off", irq, exp_irq(cyc));
      chk("ovf_irq_off_c", irq, 0);
      do_read("ovf_rd", 12'h008, 0, 0, d);
      chk("ovf_cleared", d[2:0], 3'b101);
`endif

      do_read("dec_r40", 12'h040, 0, 0, d);
      chk("dec_r40_c", {rresp, d}, {2'b10, 64'h0});
      do_read("dec_r100", 12'h100, 0, 0, d);
      do_write("dec_w40", 12'h040, 64'h1234, 8'hFF, 0, 0);
      do_write("dec_w100", 12'h100, 64'h1234, 8'hFF, 0, 0);
      for (int ch = 0; ch < NCH; ch++) do_read("dec_cnt", 12'(ch * 16), 0, 0, d);

      do_read("bp_r", 12'h030, 5, 1, d);
      do_write("bp_w", 12'h030, 64'h0BAD, 8'h03, 5, 1);
      do_read("bp_rb", 12'h030, 0, 0, d);

      for (int k = 0; k < 120; k++) begin
         logic [11:0] a;
         logic [63:0] wd;
         logic [7:0]  ws;
         int          ch;
         ch = int'($urandom_range(0, NCH));
         a = {(($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0),
              4'(ch), 1'($urandom_range(0, 1)), 3'($urandom)};
         if ($urandom_range(0, 1) == 1) begin
            wd = {$urandom, $urandom};
            ws = 8'($urandom);
            if (a[3]) wd[0] = ($urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 3) == 0) begin
               wd[15:0] = 16'hFFF0 | 16'($urandom_range(0, 15));
               ws[1:0]  = 2'b11;
            end
            do_write("rnd_w", a, wd, ws, int'($urandom_range(0, 2)), 1'b0);
         end else begin
            do_read("rnd_r", a, int'($urandom_range(0, 2)), 1'b0, d);
         end
         repeat ($urandom_range(0, 2)) tick();
         chk("rnd_irq", irq, exp_irq(cyc));
      end
      for (int ch = 0; ch < NCH; ch++) begin
         do_read("end_cnt", 12'(ch * 16), 0, 0, d);
         do_read("end_ctrl", 12'(ch * 16 + 8), 0, 0, d);
      end

      awaddr = 12'h000; wdata = 64'h1111; wstrb = 8'h03; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 12'h000; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      chk("mrst_pre_rvalid", rvalid, 1);
      chk("mrst_pre_bvalid", bvalid, 1);
      aresetn = 1'b0;
      #1;
      chk("mrst_rvalid", rvalid, 0);
      chk("mrst_bvalid", bvalid, 0);
      chk("mrst_rdata", rdata, 0);
      chk("mrst_arready", arready, 1);
      chk("mrst_irq", irq, 0);
      tick();
      tick();
      aresetn = 1'b1;
      model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         do_read("mrst_cnt", 12'(ch * 16), 0, 0, d);
         do_read("mrst_ctrl", 12'(ch * 16 + 8), 0, 0, d);
         chk("mrst_en", d[0], RSTEN);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
